qos_traffic_source: RTL and testbench

//  Ingress-side word source for the qos block: produces vc_id/data_word plus a write strobe.

---
 rtl/qos_traffic_source.sv | 133 +++++++++++++
 tb/tb_qos_traffic_source.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/qos_traffic_source.sv
// Ingress word source for the qos block: per-VC pending counts, round-robin issue of
// one word per cycle, honouring per-VC pause/resume and a fatal overflow indication.
module qos_traffic_source #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int CNT_BITS       = 4,
    localparam int VC_W = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1,
    localparam int DW   = BUF_WIDTH + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enb,
    input  logic                               load,
    input  logic [QUEUE_QUANTITY*CNT_BITS-1:0] load_counts,
    input  logic [QUEUE_QUANTITY-1:0]          pausa,
    input  logic [QUEUE_QUANTITY-1:0]          continuar,
    input  logic [QUEUE_QUANTITY-1:0]          error_full,
    output logic [VC_W-1:0]                    vc_id,
    output logic [DW-1:0]                      data_word,
    output logic                               valid,
    output logic                               done,
    output logic                               error
);

    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE, ST_ERROR} state_t;

    state_t                                    state_q, state_d;
    logic [QUEUE_QUANTITY-1:0][CNT_BITS-1:0]   count_q, count_d;
    logic [QUEUE_QUANTITY-1:0][DW-1:0]         seq_q, seq_d;
    logic [QUEUE_QUANTITY-1:0]                 paused_q, paused_d;
    logic [VC_W-1:0]                           ptr_q, ptr_d;
    logic [VC_W-1:0]                           vc_id_q, vc_id_d;
    logic [DW-1:0]                             data_q, data_d;
    logic                                      valid_q, valid_d;

    logic [QUEUE_QUANTITY-1:0]                 paused_next, elig;
    logic [VC_W-1:0]                           grant, cand;
    logic                                      found;

    // pausa dominates a simultaneous continuar on the same VC
    assign paused_next = pausa | (paused_q & ~continuar);

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            elig[i] = (count_q[i] != '0) & ~paused_next[i];
    end

    // Round-robin: first eligible VC strictly after the last grant
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
            cand = VC_W'((int'(ptr_q) + k) % QUEUE_QUANTITY);
            if (!found && elig[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        seq_d    = seq_q;
        paused_d = paused_q;
        ptr_d    = ptr_q;
        vc_id_d  = vc_id_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (enb) begin
            paused_d = paused_next;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        count_d = load_counts;
                        state_d = (load_counts != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (error_full != '0) begin
                        state_d = ST_ERROR;
                    end else if (found) begin
                        // HOLD only re-arms; the word goes out from RUN
                        state_d = ST_RUN;
                        if (state_q == ST_RUN) begin
                            vc_id_d        = grant;
                            data_d         = seq_q[grant];
                            valid_d        = 1'b1;
                            count_d[grant] = count_q[grant] - CNT_BITS'(1);
                            seq_d[grant]   = seq_q[grant] + DW'(1);
                            ptr_d          = grant;
                        end
                    end else if (count_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            seq_q    <= '0;
            paused_q <= '0;
            ptr_q    <= VC_W'(QUEUE_QUANTITY - 1);
            vc_id_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            paused_q <= paused_d;
            ptr_q    <= ptr_d;
            vc_id_q  <= vc_id_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign vc_id     = vc_id_q;
    assign data_word = data_q;
    assign valid     = valid_q;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_qos_traffic_source.sv
// Directed bench for qos_traffic_source: per-cycle vector table plus hand-written
// sequences around asynchronous reset.
module tb_qos_traffic_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_counts = '0;
    logic [3:0]  pausa = '0, continuar = '0, error_full = '0;
    logic [1:0]  vc_id;
    logic [3:0]  data_word;
    logic        valid, done, error;

    qos_traffic_source dut (
        .clk(clk), .rst(rst), .enb(enb), .load(load), .load_counts(load_counts),
        .pausa(pausa), .continuar(continuar), .error_full(error_full),
        .vc_id(vc_id), .data_word(data_word), .valid(valid), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        en, ld;
        logic [15:0] lc;
        logic [3:0]  pa, co, ef;
        logic [8:0]  exp; // {valid, vc_id, data_word, done, error}
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0, n_pass = 0;

    task automatic add(input string nm, input logic en, input logic ld, input logic [15:0] lc,
                       input logic [3:0] pa, input logic [3:0] co, input logic [3:0] ef,
                       input logic ev, input logic [1:0] evc, input logic [3:0] ed,
                       input logic edn, input logic eer);
        vec_t v;
        v.nm = nm; v.en = en; v.ld = ld; v.lc = lc; v.pa = pa; v.co = co; v.ef = ef;
        v.exp = {ev, evc, ed, edn, eer};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [8:0] want);
        logic [8:0] got;
        got = {valid, vc_id, data_word, done, error};
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got v=%0b vc=%0d d=%0d done=%0b err=%0b, want v=%0b vc=%0d d=%0d done=%0b err=%0b",
                      nm, got[8], got[7:6], got[5:2], got[1], got[0],
                      want[8], want[7:6], want[5:2], want[1], want[0]);
    endtask

    task automatic drive(input logic en, input logic ld, input logic [15:0] lc,
                         input logic [3:0] pa, input logic [3:0] co, input logic [3:0] ef);
        enb = en; load = ld; load_counts = lc; pausa = pa; continuar = co; error_full = ef;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] lc17;
        int          n17;

        // all-zero load from IDLE goes straight to DONE
        add("zero_load",  1, 1, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 0);
        // counts {3,0,0,2}
        add("t1_load",    1, 1, 16'h3002, 0, 0, 0,  0, 0, 0, 0, 0);
        add("t1_w0",      1, 0, 0,        0, 0, 0,  1, 0, 0, 0, 0);
        add("t1_w1",      1, 0, 0,        0, 0, 0,  1, 3, 0, 0, 0);
        add("t1_w2",      1, 0, 0,        0, 0, 0,  1, 0, 1, 0, 0);
        add("t1_w3",      1, 0, 0,        0, 0, 0,  1, 3, 1, 0, 0);
        add("t1_w4",      1, 0, 0,        0, 0, 0,  1, 3, 2, 0, 0);
        add("t1_done",    1, 0, 0,        0, 0, 0,  0, 3, 2, 1, 0);
        // all ones, VC1 paused 4 cycles, then continuar pulse
        add("t2_load",    1, 1, 16'h1111, 4'h2, 0, 0,  0, 3, 2, 0, 0);
        add("t2_vc0",     1, 0, 0,        4'h2, 0, 0,  1, 0, 2, 0, 0);
        add("t2_vc2",     1, 0, 0,        4'h2, 0, 0,  1, 2, 0, 0, 0);
        add("t2_vc3",     1, 0, 0,        4'h2, 0, 0,  1, 3, 3, 0, 0);
        add("t2_hold",    1, 0, 0,        0, 0, 0,     0, 3, 3, 0, 0);
        add("t2_resume",  1, 0, 0,        0, 4'h2, 0,  0, 3, 3, 0, 0);
        add("t2_vc1",     1, 0, 0,        0, 0, 0,     1, 1, 0, 0, 0);
        add("t2_done",    1, 0, 0,        0, 0, 0,     0, 1, 0, 1, 0);
        // pausa and continuar together on VC2: pause wins
        add("t3_load",    1, 1, 16'h0100, 4'h4, 4'h4, 0,  0, 1, 0, 0, 0);
        add("t3_both",    1, 0, 0,        4'h4, 4'h4, 0,  0, 1, 0, 0, 0);
        add("t3_idle",    1, 0, 0,        0, 0, 0,        0, 1, 0, 0, 0);
        add("t3_cont",    1, 0, 0,        0, 4'h4, 0,     0, 1, 0, 0, 0);
        add("t3_vc2",     1, 0, 0,        0, 0, 0,        1, 2, 1, 0, 0);
        add("t3_done",    1, 0, 0,        0, 0, 0,        0, 2, 1, 1, 0);
        // enb low for 3 cycles mid-run; inputs seen then must be ignored
        add("t5_load",    1, 1, 16'h1111, 0, 0, 0,     0, 2, 1, 0, 0);
        add("t5_vc3",     1, 0, 0,        0, 0, 0,     1, 3, 4, 0, 0);
        add("t5_off0",    0, 0, 0,        0, 0, 0,     0, 3, 4, 0, 0);
        add("t5_off1",    0, 1, 16'hffff, 4'h1, 0, 0,  0, 3, 4, 0, 0);
        add("t5_off2",    0, 0, 0,        0, 0, 4'h1,  0, 3, 4, 0, 0);
        add("t5_vc0",     1, 0, 0,        0, 0, 0,     1, 0, 3, 0, 0);
        add("t5_vc1",     1, 0, 0,        0, 0, 0,     1, 1, 1, 0, 0);
        add("t5_vc2",     1, 0, 0,        0, 0, 0,     1, 2, 2, 0, 0);
        add("t5_done",    1, 0, 0,        0, 0, 0,     0, 2, 2, 1, 0);
        // error_full with words pending: error wins over a grant, then sticky
        add("t4_load",    1, 1, 16'h2211, 0, 0, 0,     0, 2, 2, 0, 0);
        add("t4_vc3",     1, 0, 0,        0, 0, 0,     1, 3, 5, 0, 0);
        add("t4_vc0",     1, 0, 0,        0, 0, 0,     1, 0, 4, 0, 0);
        add("t4_err",     1, 0, 0,        0, 0, 4'h1,  0, 0, 4, 0, 1);
        add("t4_ldign",   1, 1, 16'h1111, 0, 0, 0,     0, 0, 4, 0, 1);
        add("t4_sticky",  1, 0, 0,        0, 0, 0,     0, 0, 4, 0, 1);

        // reset state: produce a real falling edge on rst
        #1 rst = 1'b0;
        #1 chk("reset", 9'b0);
        @(negedge clk) rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ld, vecs[i].lc, vecs[i].pa, vecs[i].co, vecs[i].ef);
            cyc();
            chk(vecs[i].nm, vecs[i].exp);
        end

        // reset clears the sticky error
        #2 rst = 1'b0;
        #1 chk("err_reset", 9'b0);
        @(negedge clk) rst = 1'b1;

        // start a run, then reset asynchronously while a word is on the outputs
        drive(1, 1, 16'h0003, 0, 0, 0);
        cyc(); chk("r_load", {1'b0, 2'd0, 4'd0, 1'b0, 1'b0});
        drive(1, 0, 0, 0, 0, 0);
        cyc(); chk("r_word", {1'b1, 2'd0, 4'd0, 1'b0, 1'b0});
        #2 rst = 1'b0;
        #1 chk("r_async", 9'b0);
        @(negedge clk) rst = 1'b1;

        // reload with VC0 = 17 truncated to 4 bits
        n17 = 17;
        lc17 = '0;
        lc17[3:0] = n17[3:0];
        drive(1, 1, lc17, 0, 0, 0);
        cyc(); chk("r17_load", {1'b0, 2'd0, 4'd0, 1'b0, 1'b0});
        drive(1, 0, 0, 0, 0, 0);
        cyc(); chk("r17_word", {1'b1, 2'd0, 4'd0, 1'b0, 1'b0});
        cyc(); chk("r17_done", {1'b0, 2'd0, 4'd0, 1'b1, 1'b0});
        cyc(); chk("r17_stay", {1'b0, 2'd0, 4'd0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
